// File: rtl/line_render_sequencer.sv
// Per-scanline scheduler: prepare_line -> sprite_drawer -> line-buffer swap, with overrun abort.
// Optional feature macro: LRS_OVERRUN_CNT_EN builds the saturating overrun counter.
module line_render_sequencer #(
  parameter int CORDW   = 10,
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int V_RES   = 480,
  parameter int START_X = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  output logic             prep_start,
  input  logic             prep_done,
  output logic             draw_start,
  input  logic             draw_done,
  output logic             oam_sel,
  output logic [CORDW-1:0] target_line,
  output logic             abort,
  output logic             buffer_swap,
  output logic             line_valid,
  output logic [7:0]       overrun_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PREP  = 2'd1;
  localparam logic [1:0] S_DRAW  = 2'd2;
  localparam logic [1:0] S_READY = 2'd3;

  logic [1:0]       state;
  logic [CORDW-1:0] tgt;
  logic             in_frame, trigger, boundary, swap_evt, abort_evt;

  // Line L is rendered during scan line L-1; line 0 during the last frame line.
  always_comb begin
    in_frame  = (sy < CORDW'(V_TOTAL));
    tgt       = (sy == CORDW'(V_TOTAL-1)) ? '0 : sy + 1'b1;
    trigger   = in_frame && (sx == CORDW'(START_X)) && (tgt < CORDW'(V_RES));
    boundary  = in_frame && (sx == CORDW'(H_TOTAL-1)) && (tgt == target_line);
    swap_evt  = boundary && ((state == S_READY) || ((state == S_DRAW) && draw_done));
    abort_evt = boundary && ((state == S_PREP) || ((state == S_DRAW) && !draw_done));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      prep_start  <= 1'b0;
      draw_start  <= 1'b0;
      oam_sel     <= 1'b0;
      target_line <= '0;
      abort       <= 1'b0;
      buffer_swap <= 1'b0;
      line_valid  <= 1'b0;
    end else begin
      prep_start  <= 1'b0;
      draw_start  <= 1'b0;
      abort       <= 1'b0;
      buffer_swap <= 1'b0;
      if (in_frame && (sy == CORDW'(V_RES))) line_valid <= 1'b0;
      if (swap_evt) begin
        buffer_swap <= 1'b1;
        line_valid  <= 1'b1;
        oam_sel     <= 1'b0;
        state       <= S_IDLE;
      end else if (abort_evt) begin
        abort      <= 1'b1;
        line_valid <= 1'b0;
        oam_sel    <= 1'b0;
        state      <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (trigger) begin
            target_line <= tgt;
            prep_start  <= 1'b1;
            oam_sel     <= 1'b0;
            state       <= S_PREP;
          end
          // prep_done is only trusted after the prep_start cycle
          S_PREP: if (prep_done && !prep_start) begin
            draw_start <= 1'b1;
            oam_sel    <= 1'b1;
            state      <= S_DRAW;
          end
          S_DRAW: if (draw_done) state <= S_READY;
          default: ;
        endcase
      end
    end
  end

`ifdef LRS_OVERRUN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overrun_count <= 8'h00;
    else if (abort_evt && (overrun_count != 8'hFF))
      overrun_count <= overrun_count + 8'd1;
  end
`else
  assign overrun_count = 8'h00;
`endif

endmodule

// File: tb/tb_line_render_sequencer.sv
// Directed self-checking bench for line_render_sequencer; sx/sy are driven by the bench.
module tb_line_render_sequencer;
  localparam int CORDW = 10;
  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 525;
`ifdef LRS_OVERRUN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CORDW-1:0] sx = '0, sy = '0;
  logic             prep_done = 1'b0, draw_done = 1'b0;
  logic             prep_start, draw_start, oam_sel, abort, buffer_swap, line_valid;
  logic [CORDW-1:0] target_line;
  logic [7:0]       overrun_count;
  int               n_checks = 0;
  int               n_fail = 0;

  line_render_sequencer dut (
    .clk(clk), .rst_n(rst_n), .sx(sx), .sy(sy),
    .prep_start(prep_start), .prep_done(prep_done),
    .draw_start(draw_start), .draw_done(draw_done),
    .oam_sel(oam_sel), .target_line(target_line), .abort(abort),
    .buffer_swap(buffer_swap), .line_valid(line_valid), .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  // One pixel clock: outputs settle from the edge, then the raster advances.
  task automatic clk1();
    @(posedge clk); #1;
    if (sx == CORDW'(H_TOTAL-1)) begin
      sx = '0;
      sy = (sy == CORDW'(V_TOTAL-1)) ? '0 : sy + 1'b1;
    end else sx = sx + 1'b1;
  endtask

  task automatic jump(input int y, input int x);
    sy = CORDW'(y); sx = CORDW'(x);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; prep_done = 1'b0; draw_done = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Trigger on line y (target y+1), optionally complete prep/draw, then hit the boundary.
  task automatic do_line(input int y, input bit give_prep, input bit give_draw);
    jump(y, 0); clk1(); clk1();
    if (give_prep) begin prep_done = 1'b1; clk1(); prep_done = 1'b0; clk1(); end
    if (give_draw) begin draw_done = 1'b1; clk1(); draw_done = 1'b0; end
    jump(y, H_TOTAL-1); clk1();
  endtask

  task automatic test_reset();
    logic [7:0] exp_cnt;
    bit any_pulse;
    jump(10, 5); rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({prep_start, draw_start, oam_sel, abort, buffer_swap, line_valid} !== 6'b0 ||
        target_line !== '0 || overrun_count !== 8'h00) begin
      n_fail++; $display("FAIL reset_outputs: got ps=%b ds=%b oam=%b ab=%b sw=%b lv=%b tl=%0d oc=%0d, want all 0",
        prep_start, draw_start, oam_sel, abort, buffer_swap, line_valid, target_line, overrun_count);
    end
    rst_n = 1'b1;
    any_pulse = 1'b0;
    repeat (795) begin
      clk1();
      if (prep_start || draw_start || abort || buffer_swap) any_pulse = 1'b1;
    end
    n_checks++;
    if (any_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_quiet: got pulse=%b want 0", any_pulse); end
    clk1();
    n_checks++;
    if (prep_start !== 1'b1 || target_line !== CORDW'(12)) begin
      n_fail++; $display("FAIL reset_first_trigger: got ps=%b tl=%0d want ps=1 tl=12", prep_start, target_line);
    end
    clk1();
    n_checks++;
    if (prep_start !== 1'b0) begin n_fail++; $display("FAIL prep_start_width: got %b want 0", prep_start); end
    jump(11, H_TOTAL-1); clk1();
    exp_cnt = CNT_EN ? 8'd1 : 8'd0;
    n_checks++;
    if (abort !== 1'b1 || overrun_count !== exp_cnt) begin
      n_fail++; $display("FAIL reset_prep_abort: got ab=%b oc=%0d want ab=1 oc=%0d", abort, overrun_count, exp_cnt);
    end
  endtask

  task automatic test_line0();
    bit bad;
    apply_reset();
    jump(V_TOTAL-1, 0); clk1();
    n_checks++;
    if (prep_start !== 1'b1 || target_line !== '0 || oam_sel !== 1'b0) begin
      n_fail++; $display("FAIL line0_prep: got ps=%b tl=%0d oam=%b want 1 0 0", prep_start, target_line, oam_sel);
    end
    repeat (19) clk1();
    prep_done = 1'b1; clk1(); prep_done = 1'b0;
    n_checks++;
    if (draw_start !== 1'b1 || oam_sel !== 1'b1) begin
      n_fail++; $display("FAIL line0_draw_start: got ds=%b oam=%b want 1 1", draw_start, oam_sel);
    end
    bad = 1'b0;
    repeat (299) begin
      clk1();
      if (oam_sel !== 1'b1 || draw_start !== 1'b0 || buffer_swap !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL line0_draw_hold: got glitch=%b want 0", bad); end
    draw_done = 1'b1; clk1(); draw_done = 1'b0;
    n_checks++;
    if (oam_sel !== 1'b1 || buffer_swap !== 1'b0) begin
      n_fail++; $display("FAIL line0_ready: got oam=%b sw=%b want 1 0", oam_sel, buffer_swap);
    end
    jump(V_TOTAL-1, H_TOTAL-1); clk1();
    n_checks++;
    if (buffer_swap !== 1'b1 || line_valid !== 1'b1 || oam_sel !== 1'b0 || abort !== 1'b0) begin
      n_fail++; $display("FAIL line0_swap: got sw=%b lv=%b oam=%b ab=%b want 1 1 0 0",
        buffer_swap, line_valid, oam_sel, abort);
    end
    clk1();
    n_checks++;
    if (buffer_swap !== 1'b0 || line_valid !== 1'b1) begin
      n_fail++; $display("FAIL line0_swap_width: got sw=%b lv=%b want 0 1", buffer_swap, line_valid);
    end
  endtask

  task automatic test_blanking();
    bit any_prep;
    jump(479, 0); clk1();
    n_checks++;
    if (prep_start !== 1'b0 || line_valid !== 1'b1) begin
      n_fail++; $display("FAIL blank_479: got ps=%b lv=%b want 0 1", prep_start, line_valid);
    end
    any_prep = 1'b0;
    for (int y = 480; y <= 523; y++) begin
      jump(y, 0); clk1();
      if (prep_start) any_prep = 1'b1;
      if (y == 480) begin
        n_checks++;
        if (line_valid !== 1'b0) begin n_fail++; $display("FAIL blank_valid_clear: got %b want 0", line_valid); end
      end
    end
    n_checks++;
    if (any_prep !== 1'b0) begin n_fail++; $display("FAIL blank_no_prep: got %b want 0", any_prep); end
    jump(600, 0); clk1();
    n_checks++;
    if (prep_start !== 1'b0) begin n_fail++; $display("FAIL out_of_frame: got ps=%b want 0", prep_start); end
  endtask

  task automatic test_overrun();
    logic [7:0] exp_cnt;
    apply_reset();
    do_line(98, 1'b1, 1'b1);
    n_checks++;
    if (buffer_swap !== 1'b1 || line_valid !== 1'b1) begin
      n_fail++; $display("FAIL ovr_pre_swap: got sw=%b lv=%b want 1 1", buffer_swap, line_valid);
    end
    do_line(99, 1'b1, 1'b0);
    exp_cnt = CNT_EN ? 8'd1 : 8'd0;
    n_checks++;
    if (abort !== 1'b1 || buffer_swap !== 1'b0 || line_valid !== 1'b0 || oam_sel !== 1'b0 ||
        overrun_count !== exp_cnt || sy !== CORDW'(100) || sx !== '0) begin
      n_fail++; $display("FAIL ovr_draw_abort: got ab=%b sw=%b lv=%b oam=%b oc=%0d want 1 0 0 0 oc=%0d",
        abort, buffer_swap, line_valid, oam_sel, overrun_count, exp_cnt);
    end
    clk1();
    n_checks++;
    if (abort !== 1'b0) begin n_fail++; $display("FAIL ovr_abort_width: got %b want 0", abort); end
    do_line(100, 1'b0, 1'b0);
    exp_cnt = CNT_EN ? 8'd2 : 8'd0;
    n_checks++;
    if (abort !== 1'b1 || overrun_count !== exp_cnt) begin
      n_fail++; $display("FAIL ovr_prep_abort: got ab=%b oc=%0d want 1 %0d", abort, overrun_count, exp_cnt);
    end
  endtask

  task automatic test_coincident();
    logic [7:0] exp_cnt;
    jump(200, 0); clk1(); clk1();
    prep_done = 1'b1; clk1(); prep_done = 1'b0; clk1();
    jump(200, H_TOTAL-1); draw_done = 1'b1; clk1(); draw_done = 1'b0;
    exp_cnt = CNT_EN ? 8'd2 : 8'd0;
    n_checks++;
    if (buffer_swap !== 1'b1 || abort !== 1'b0 || line_valid !== 1'b1 || overrun_count !== exp_cnt) begin
      n_fail++; $display("FAIL coincident_done: got sw=%b ab=%b lv=%b oc=%0d want 1 0 1 %0d",
        buffer_swap, abort, line_valid, overrun_count, exp_cnt);
    end
  endtask

  task automatic test_ignore();
    bit bad;
    logic [7:0] exp_cnt;
    jump(150, 0); draw_done = 1'b1; clk1();
    bad = 1'b0;
    repeat (3) begin clk1(); if (draw_start || oam_sel) bad = 1'b1; end
    draw_done = 1'b0;
    n_checks++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL ignore_draw_in_prep: got %b want 0", bad); end
    jump(150, H_TOTAL-1); clk1();
    exp_cnt = CNT_EN ? 8'd3 : 8'd0;
    n_checks++;
    if (abort !== 1'b1 || buffer_swap !== 1'b0 || overrun_count !== exp_cnt) begin
      n_fail++; $display("FAIL ignore_abort: got ab=%b sw=%b oc=%0d want 1 0 %0d", abort, buffer_swap, overrun_count, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    jump(300, 0); clk1(); clk1();
    prep_done = 1'b1; clk1(); prep_done = 1'b0; clk1();
    n_checks++;
    if (oam_sel !== 1'b1 || target_line !== CORDW'(301)) begin
      n_fail++; $display("FAIL mid_in_draw: got oam=%b tl=%0d want 1 301", oam_sel, target_line);
    end
    rst_n = 1'b0; #1;
    n_checks++;
    if ({prep_start, draw_start, oam_sel, abort, buffer_swap, line_valid} !== 6'b0 ||
        target_line !== '0 || overrun_count !== 8'h00) begin
      n_fail++; $display("FAIL mid_reset_outputs: got oam=%b ab=%b lv=%b tl=%0d oc=%0d want all 0",
        oam_sel, abort, line_valid, target_line, overrun_count);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    jump(300, H_TOTAL-1); clk1();
    n_checks++;
    if (abort !== 1'b0 || buffer_swap !== 1'b0) begin
      n_fail++; $display("FAIL mid_no_abort: got ab=%b sw=%b want 0 0", abort, buffer_swap);
    end
    jump(310, 0); clk1();
    n_checks++;
    if (prep_start !== 1'b1 || target_line !== CORDW'(311) || oam_sel !== 1'b0) begin
      n_fail++; $display("FAIL mid_restart: got ps=%b tl=%0d oam=%b want 1 311 0", prep_start, target_line, oam_sel);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] exp_cnt;
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      do_line(50, 1'b0, 1'b0);
      if (i == 9) begin
        exp_cnt = CNT_EN ? 8'd10 : 8'd0;
        n_checks++;
        if (overrun_count !== exp_cnt) begin
          n_fail++; $display("FAIL sat_count10: got %0d want %0d", overrun_count, exp_cnt);
        end
      end
    end
    exp_cnt = CNT_EN ? 8'd255 : 8'd0;
    n_checks++;
    if (overrun_count !== exp_cnt || abort !== 1'b1) begin
      n_fail++; $display("FAIL sat_count255: got oc=%0d ab=%b want %0d 1", overrun_count, abort, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_line0();
    test_blanking();
    test_overrun();
    test_coincident();
    test_ignore();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
